playback_sequencer: RTL and testbench
=====================================

PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

Interface
REQ-001 SHALL have parameter SYMS, default 16, meaning symbols per input word (2..64).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the word request and word counters.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 resetN  input  1  reset, asynchronous and active-low; asynchronous assert, release synchronous to clk.
REQ-005 enable  input  1  level; starts a run from IDLE and must drop to leave DONE.
REQ-006 loopMode  input  1  when 1 at the end of the last word, the run restarts instead of completing.
REQ-007 abort  input  1  synchronous; terminates any run.
REQ-008 requestNum  input  CNT_W  words per run; sampled on the IDLE->FETCH transition only.
REQ-009 wordData  input  2*SYMS  symbol i = {bit 2i+1 enable, bit 2i out}; symbol 0 plays first.
REQ-010 wordValid  input  1  upstream word available.
REQ-011 wordReady  output  1  word accepted on any edge where wordValid and wordReady are both 1.
REQ-012 playbackClk  input  1  asynchronous symbol-rate strobe; each rising edge advances one symbol.
REQ-013 dOut  output  1  current symbol data.
REQ-014 dEnable  output  1  current symbol drive enable.
REQ-015 busy  output  1  high in FETCH, PLAY and STALL.
REQ-016 complete  output  1  high in DONE only.
REQ-017 underrun  output  1  sticky; set on entry to STALL.
REQ-018 wordCount  output  CNT_W  words fully played in the current run.

Function
REQ-019 playbackClk SHALL pass through a 2-flop synchronizer plus edge register; tick = sync2 & ~sync3, one clk cycle wide per rising edge.
REQ-020 Holding registers SHALL be: active word (cur), one pending word (pend, with pendValid), symbol index idx, acceptCount, wordCount.
REQ-021 States SHALL be IDLE, FETCH, PLAY, STALL, DONE.
REQ-022 IDLE: if enable=1 and requestNum!=0 -> FETCH, with counters cleared and requestNum latched; if enable=1 and requestNum=0 -> DONE.
REQ-023 FETCH: on word handshake, load cur, set idx=0, acceptCount+1, and go to PLAY.
REQ-024 In PLAY and STALL, wordReady SHALL be 1 only when pendValid=0 and acceptCount < latched requestNum; an accepted word loads pend.
REQ-025 In IDLE, FETCH and DONE, wordReady SHALL be 1 in FETCH only.
REQ-026 PLAY with tick and idx<SYMS-1: idx+1 on the next edge.
REQ-027 PLAY with tick and idx=SYMS-1 SHALL first do wordCount+1, then take exactly one of these branches:
- wordCount+1 = requestNum and loopMode=0 -> DONE.
- wordCount+1 = requestNum and loopMode=1 -> clear both counters and go to FETCH; pend is empty by construction.
- pendValid=1 -> cur<=pend, pendValid<=0, idx<=0, stay in PLAY; there is no gap symbol.
- otherwise -> STALL with underrun<=1.
REQ-028 STALL: the first accepted word loads cur directly with idx=0 and returns to PLAY; ticks during STALL are discarded.
REQ-029 If a handshake and a cur<-pend transfer coincide on one edge, the transfer SHALL win and the new word SHALL land in pend; no word is lost or duplicated.
REQ-030 In PLAY, dOut/dEnable SHALL be combinational selects of cur symbol idx; in all other states both SHALL be 0.
REQ-031 The idx counter SHALL be wide enough for SYMS-1 and never exceed it.
REQ-032 The counters SHALL be saturating-free; requestNum up to 2^CNT_W-1 is legal.
REQ-033 abort=1 SHALL force DONE on the next edge from any state, clear pendValid, and leave counters frozen.
REQ-034 abort in IDLE SHALL go to DONE.
REQ-035 DONE -> IDLE when enable=0; underrun SHALL clear on the IDLE->FETCH transition.
REQ-036 requestNum/loopMode changes mid-run SHALL NOT affect the run; loopMode is sampled at the last-word boundary.

Reset
REQ-037 resetN=0 SHALL immediately force the following, with no clk needed:
- state=IDLE.
- cur=0, pend=0, pendValid=0, idx=0.
- acceptCount=0, wordCount=0.
- underrun=0 and synchronizer flops=0.
- dOut=0, dEnable=0, wordReady=0, busy=0, complete=0.
REQ-038 Reset mid-run SHALL discard all buffered words; after release, the block SHALL wait in IDLE with no tick generated from stale playbackClk state.

Verification
REQ-039 SYMS=16, requestNum=2, words A, B always valid, 32 playbackClk edges -> A[0..15] then B[0..15] on {dEnable,dOut}, no gap, complete=1, wordCount=2.
REQ-040 requestNum=3, word 2 withheld until 5 ticks after word 1 ends -> STALL, dEnable=0, underrun=1, then word 2 plays from symbol 0, complete with wordCount=3.
REQ-041 loopMode=1, requestNum=1 -> after 16 ticks wordCount returns to 0, FETCH reasserts wordReady, complete stays 0.
REQ-042 abort pulsed at idx=7 of word 1 with pend full -> next cycle DONE, outputs 0, pendValid=0, wordCount=0; enable=0 -> IDLE.
REQ-043 resetN low asynchronously mid-PLAY -> outputs 0 before the next clk edge; after release with enable=0, the block stays in IDLE.
REQ-044 requestNum=0 with enable=1 -> DONE in 1 cycle, wordReady never asserted.

Source files
------------

// File: rtl/playback_sequencer.sv
// ---------------------------------------------------------------------------
// playback_sequencer
//
// Purpose
//   Takes words of SYMS two-bit symbols from an upstream valid/ready source.
//   It plays one symbol per rising edge of an asynchronous symbol-rate strobe
//   (playbackClk). Symbol i of a word is {wordData[2i+1] = enable,
//   wordData[2i] = data}, and symbol 0 plays first. One pending word is
//   buffered behind the active one, so consecutive words play back-to-back
//   with no gap symbol.
//
// Ports
//   clk, resetN         clock; asynchronous active-low reset
//   enable              level: starts a run from IDLE, must drop to leave DONE
//   loopMode            restart instead of completing at the last word
//   abort               synchronous: terminate any run (-> DONE)
//   requestNum          words per run, latched when the run starts
//   wordData/wordValid  upstream word and its valid flag
//   wordReady           word accepted on an edge with wordValid & wordReady
//   playbackClk         asynchronous symbol strobe (rising edge = next symbol)
//   dOut, dEnable       current symbol (0 outside PLAY)
//   busy, complete      FETCH/PLAY/STALL, and DONE
//   underrun            sticky: set on entering STALL, cleared on run start
//   wordCount           words fully played in the current run
//   o_dbg_state         FSM state, for observation and checkers
//
// Handshake
//   A word transfers on every rising clk edge where wordValid and wordReady
//   are both 1. wordReady does not depend on wordValid. wordReady is held low
//   while abort is high, so an aborted cycle never consumes a word.
// ---------------------------------------------------------------------------
module playback_sequencer #(
  parameter int SYMS  = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               enable,
  input  logic               loopMode,
  input  logic               abort,
  input  logic [CNT_W-1:0]   requestNum,
  input  logic [2*SYMS-1:0]  wordData,
  input  logic               wordValid,
  output logic               wordReady,
  input  logic               playbackClk,
  output logic               dOut,
  output logic               dEnable,
  output logic               busy,
  output logic               complete,
  output logic               underrun,
  output logic [CNT_W-1:0]   wordCount,
  output logic [2:0]         o_dbg_state
);

  localparam int IDX_W = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_PLAY  = 3'd2,
    S_STALL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic [2*SYMS-1:0]   r_cur;
  logic [2*SYMS-1:0]   r_pend;
  logic                r_pend_valid;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_accept_cnt;
  logic [CNT_W-1:0]    r_word_cnt;
  logic [CNT_W-1:0]    r_req_num;
  logic                r_underrun;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_sync3;

  logic                w_tick;
  logic                w_ready;
  logic                w_hs;
  logic                w_last_sym;
  logic [CNT_W-1:0]    w_wc_inc;

  // Two-flop synchronizer plus an edge register. The tick is one clk cycle
  // wide per rising edge of playbackClk.
  assign w_tick     = r_sync2 & ~r_sync3;
  assign w_last_sym = (r_idx == LAST_IDX);
  assign w_wc_inc   = r_word_cnt + CNT_W'(1);

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_FETCH:         w_ready = 1'b1;
      S_PLAY, S_STALL: w_ready = ~r_pend_valid && (r_accept_cnt < r_req_num);
      default:         w_ready = 1'b0;
    endcase
  end

  assign wordReady = w_ready & ~abort;
  assign w_hs      = wordValid & wordReady;

  // Symbol output is a plain select of the active word while playing.
  always_comb begin
    dOut    = 1'b0;
    dEnable = 1'b0;
    if (r_state == S_PLAY) begin
      dOut    = r_cur[{r_idx, 1'b0}];
      dEnable = r_cur[{r_idx, 1'b1}];
    end
  end

  assign busy        = (r_state == S_FETCH) || (r_state == S_PLAY) ||
                       (r_state == S_STALL);
  assign complete    = (r_state == S_DONE);
  assign underrun    = r_underrun;
  assign wordCount   = r_word_cnt;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= S_IDLE;
      r_cur        <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_idx        <= '0;
      r_accept_cnt <= '0;
      r_word_cnt   <= '0;
      r_req_num    <= '0;
      r_underrun   <= 1'b0;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync3      <= 1'b0;
    end else begin
      r_sync1 <= playbackClk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;

      if (abort) begin
        // Counters stay frozen so the aborted run's progress stays visible.
        r_state      <= S_DONE;
        r_pend_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (enable) begin
              if (requestNum != '0) begin
                r_state      <= S_FETCH;
                r_req_num    <= requestNum;
                r_accept_cnt <= '0;
                r_word_cnt   <= '0;
                r_pend_valid <= 1'b0;
                r_underrun   <= 1'b0;
              end else begin
                r_state <= S_DONE;
              end
            end
          end

          S_FETCH: begin
            if (w_hs) begin
              r_cur        <= wordData;
              r_idx        <= '0;
              r_accept_cnt <= r_accept_cnt + CNT_W'(1);
              r_state      <= S_PLAY;
            end
          end

          S_PLAY: begin
            // An accepted word always goes to pend. If it coincides with a
            // cur<-pend transfer below, the transfer reads the old pend and
            // the new word stays in pend.
            if (w_hs) begin
              r_pend       <= wordData;
              r_pend_valid <= 1'b1;
              r_accept_cnt <= r_accept_cnt + CNT_W'(1);
            end
            if (w_tick) begin
              if (!w_last_sym) begin
                r_idx <= r_idx + IDX_W'(1);
              end else begin
                r_word_cnt <= w_wc_inc;
                if (w_wc_inc == r_req_num) begin
                  if (loopMode) begin
                    r_word_cnt   <= '0;
                    r_accept_cnt <= '0;
                    r_state      <= S_FETCH;
                  end else begin
                    r_state <= S_DONE;
                  end
                end else if (r_pend_valid) begin
                  r_cur        <= r_pend;
                  r_idx        <= '0;
                  r_pend_valid <= w_hs;
                end else begin
                  r_state    <= S_STALL;
                  r_underrun <= 1'b1;
                end
              end
            end
          end

          S_STALL: begin
            // Ticks are dropped here. A word accepted on the same edge that
            // entered STALL sits in pend and is promoted at once. Otherwise
            // the next accepted word goes straight into cur.
            if (r_pend_valid) begin
              r_cur        <= r_pend;
              r_pend_valid <= 1'b0;
              r_idx        <= '0;
              r_state      <= S_PLAY;
            end else if (w_hs) begin
              r_cur        <= wordData;
              r_idx        <= '0;
              r_accept_cnt <= r_accept_cnt + CNT_W'(1);
              r_state      <= S_PLAY;
            end
          end

          S_DONE: begin
            if (!enable) r_state <= S_IDLE;
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_playback_sequencer.sv
module tb_playback_sequencer;

  localparam int SYMS  = 16;
  localparam int CNT_W = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_STALL = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic              clk;
  logic              resetN;
  logic              enable;
  logic              loopMode;
  logic              abort;
  logic [CNT_W-1:0]  requestNum;
  logic [2*SYMS-1:0] wordData;
  logic              wordValid;
  logic              wordReady;
  logic              playbackClk;
  logic              dOut;
  logic              dEnable;
  logic              busy;
  logic              complete;
  logic              underrun;
  logic [CNT_W-1:0]  wordCount;
  logic [2:0]        o_dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] word_a = 32'hC3A5_96E1;
  logic [31:0] word_b = 32'h5AF0_0FB7;
  logic [31:0] word_c = 32'h9D3C_E14B;

  playback_sequencer #(.SYMS(SYMS), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .enable      (enable),
    .loopMode    (loopMode),
    .abort       (abort),
    .requestNum  (requestNum),
    .wordData    (wordData),
    .wordValid   (wordValid),
    .wordReady   (wordReady),
    .playbackClk (playbackClk),
    .dOut        (dOut),
    .dEnable     (dEnable),
    .busy        (busy),
    .complete    (complete),
    .underrun    (underrun),
    .wordCount   (wordCount),
    .o_dbg_state (o_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sym_of(input logic [31:0] w, input int k);
    return w[2*k +: 2];
  endfunction

  // Drivers (called at posedge+1)
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One playbackClk rising edge, then enough cycles that the tick has acted
  // and the synchronizer has settled low again.
  task automatic pb_tick();
    playbackClk = 1'b1;
    cyc(2);
    playbackClk = 1'b0;
    cyc(3);
  endtask

  task automatic send_word(input logic [31:0] d, input string tag);
    int n;
    n = 0;
    wordData  = d;
    wordValid = 1'b1;
    while (wordReady !== 1'b1 && n < 40) begin
      cyc(1);
      n++;
    end
    chk({tag, "_ready"}, wordReady, 1'b1);
    cyc(1);
    wordValid = 1'b0;
  endtask

  initial begin
    resetN      = 1'b0;
    enable      = 1'b0;
    loopMode    = 1'b0;
    abort       = 1'b0;
    requestNum  = '0;
    wordData    = '0;
    wordValid   = 1'b0;
    playbackClk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",    o_dbg_state, ST_IDLE);
    chk("rst_outs",     {dOut, dEnable, wordReady, busy, complete, underrun}, 6'b0);
    chk("rst_wordcnt",  wordCount, 16'd0);
    @(negedge clk);
    resetN = 1'b1;
    cyc(1);
    chk("idle_hold", o_dbg_state, ST_IDLE);

    // Run 1: two words, back-to-back, no gap
    requestNum = 16'd2;
    enable     = 1'b1;
    cyc(1);
    chk("r1_fetch", o_dbg_state, ST_FETCH);
    chk("r1_busy",  busy, 1'b1);
    send_word(word_a, "r1_a");
    send_word(word_b, "r1_b");
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("r1_sym%0d", k), {dEnable, dOut},
          (k < 16) ? sym_of(word_a, k) : sym_of(word_b, k - 16));
      if (k == 16) chk("r1_wc_mid", wordCount, 16'd1);
      pb_tick();
    end
    chk("r1_done",     o_dbg_state, ST_DONE);
    chk("r1_complete", complete, 1'b1);
    chk("r1_wc",       wordCount, 16'd2);
    chk("r1_outs0",    {dEnable, dOut, busy}, 3'b000);
    chk("r1_no_urun",  underrun, 1'b0);
    enable = 1'b0;
    cyc(1);
    chk("r1_idle", o_dbg_state, ST_IDLE);

    // Run 2: third word withheld -> STALL, underrun
    requestNum = 16'd3;
    enable     = 1'b1;
    cyc(1);
    send_word(word_a, "r2_a");
    send_word(word_b, "r2_b");
    for (int k = 0; k < 32; k++) pb_tick();
    chk("r2_stall",     o_dbg_state, ST_STALL);
    chk("r2_stall_out", {dEnable, dOut}, 2'b00);
    chk("r2_urun",      underrun, 1'b1);
    chk("r2_stall_wc",  wordCount, 16'd2);
    chk("r2_stall_rdy", wordReady, 1'b1);
    for (int k = 0; k < 5; k++) pb_tick();
    chk("r2_still_stall", o_dbg_state, ST_STALL);
    send_word(word_c, "r2_c");
    chk("r2_play", o_dbg_state, ST_PLAY);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("r2_sym%0d", k), {dEnable, dOut}, sym_of(word_c, k));
      pb_tick();
    end
    chk("r2_done",  o_dbg_state, ST_DONE);
    chk("r2_wc",    wordCount, 16'd3);
    chk("r2_urun_sticky", underrun, 1'b1);
    enable = 1'b0;
    cyc(1);
    chk("r2_urun_idle", underrun, 1'b1);

    // Run 3: loop mode, one word per run
    requestNum = 16'd1;
    loopMode   = 1'b1;
    enable     = 1'b1;
    cyc(1);
    chk("r3_urun_clr", underrun, 1'b0);
    send_word(word_b, "r3_b");
    for (int k = 0; k < 16; k++) pb_tick();
    chk("r3_refetch", o_dbg_state, ST_FETCH);
    chk("r3_rdy",     wordReady, 1'b1);
    chk("r3_wc0",     wordCount, 16'd0);
    chk("r3_nocomp",  complete, 1'b0);
    loopMode = 1'b0;
    send_word(word_c, "r3_c");
    for (int k = 0; k < 16; k++) pb_tick();
    chk("r3_done", o_dbg_state, ST_DONE);
    chk("r3_wc1",  wordCount, 16'd1);
    enable = 1'b0;
    cyc(1);

    // Run 4: abort at idx 7 of word 1 with pend full
    requestNum = 16'd3;
    enable     = 1'b1;
    cyc(1);
    send_word(word_a, "r4_a");
    send_word(word_b, "r4_b");
    for (int k = 0; k < 7; k++) pb_tick();
    chk("r4_sym7",     {dEnable, dOut}, sym_of(word_a, 7));
    chk("r4_pendfull", wordReady, 1'b0);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("r4_done",  o_dbg_state, ST_DONE);
    chk("r4_outs",  {dEnable, dOut, busy, wordReady}, 4'b0000);
    chk("r4_comp",  complete, 1'b1);
    chk("r4_wc",    wordCount, 16'd0);
    enable = 1'b0;
    cyc(1);
    chk("r4_idle", o_dbg_state, ST_IDLE);

    // Abort from IDLE
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("ab_idle_done", o_dbg_state, ST_DONE);
    cyc(1);
    chk("ab_idle_back", o_dbg_state, ST_IDLE);

    // requestNum = 0: straight to DONE, wordReady never high
    requestNum = 16'd0;
    wordValid  = 1'b1;
    wordData   = word_c;
    enable     = 1'b1;
    chk("z_rdy_idle", wordReady, 1'b0);
    cyc(1);
    chk("z_done", o_dbg_state, ST_DONE);
    chk("z_rdy0", wordReady, 1'b0);
    cyc(1);
    chk("z_rdy1", wordReady, 1'b0);
    chk("z_wc",   wordCount, 16'd0);
    wordValid = 1'b0;
    enable    = 1'b0;
    cyc(1);

    // Asynchronous reset mid-PLAY
    requestNum = 16'd2;
    enable     = 1'b1;
    cyc(1);
    send_word(word_a, "rs_a");
    for (int k = 0; k < 3; k++) pb_tick();
    chk("rs_sym3", {dEnable, dOut}, sym_of(word_a, 3));
    playbackClk = 1'b1;
    #2 resetN = 1'b0;
    #1;
    chk("rs_async_outs",  {dEnable, dOut, busy, complete, wordReady}, 5'b0);
    chk("rs_async_state", o_dbg_state, ST_IDLE);
    enable = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    cyc(6);
    chk("rs_stay_idle", o_dbg_state, ST_IDLE);
    chk("rs_idle_outs", {dEnable, dOut, busy, wordReady}, 4'b0);
    playbackClk = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
